// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - state/direction encodings and code helpers for the ADPLL loop controller
package adpll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COARSE = 2'd1,
      ST_FINE   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   function automatic int unsigned mid_code(input int unsigned width);
      return 32'd1 << (width - 1);
   endfunction

   // Simultaneous or absent UP/DN carries no frequency information.
   function automatic dir_t pfd_dir(input logic up, input logic dn);
      if (up && !dn) return DIR_UP;
      if (dn && !up) return DIR_DN;
      return DIR_NONE;
   endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// rtl/adpll_lock_detect.sv - direction-reversal lock counter and fine-rail loss counter
module adpll_lock_detect
   import adpll_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CYC = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  dir_t dir_i,
   input  logic rail_i,
   output logic rev_hit_o,
   output logic lock_hit_o,
   output logic loss_hit_o
);

   localparam int RW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CYC + 1);

   dir_t          last_q, last_d;
   logic [RW-1:0] rev_q, rev_d;
   logic [LW-1:0] rail_q, rail_d;

   assign rev_hit_o  = !clr_i && (dir_i != DIR_NONE) && (last_q != DIR_NONE) && (dir_i != last_q);
   assign lock_hit_o = !clr_i && (rev_d == RW'(LOCK_CNT));
   assign loss_hit_o = !clr_i && rail_i && (rail_q == LW'(LOSS_CYC - 1));

   always_comb begin
      last_d = last_q;
      rev_d  = rev_q;
      rail_d = rail_q;
      if (clr_i) begin
         last_d = DIR_NONE;
         rev_d  = '0;
         rail_d = '0;
      end else begin
         if (dir_i != DIR_NONE) begin
            last_d = dir_i;
            if (rev_hit_o)
               rev_d = (rev_q == RW'(LOCK_CNT)) ? rev_q : rev_q + RW'(1);
            else if (last_q != DIR_NONE)
               rev_d = '0;
         end
         if (!rail_i)
            rail_d = '0;
         else if (rail_q != LW'(LOSS_CYC))
            rail_d = rail_q + LW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= DIR_NONE;
         rev_q  <= '0;
         rail_q <= '0;
      end else begin
         last_q <= last_d;
         rev_q  <= rev_d;
         rail_q <= rail_d;
      end
   end

endmodule

// File: rtl/adpll_lock_ctrl.sv
// rtl/adpll_lock_ctrl.sv - ADPLL SAR coarse calibration then bang-bang fine tracking with lock/loss
// Optional: ADPLL_FAST_TRACK_EN enables step-4 fine tracking until the first reversal.
module adpll_lock_ctrl
   import adpll_pkg::*;
#(
   parameter int CW         = 6,
   parameter int FW         = 6,
   parameter int SETTLE_CYC = 16,
   parameter int LOCK_CNT   = 8,
   parameter int LOSS_CYC   = 32
) (
   input  logic          REF_CLK,
   input  logic          RESET,
   input  logic          START,
   input  logic [2:0]    M,
   input  logic          PFD_UP,
   input  logic          PFD_DN,
   output logic [CW-1:0] DCO_COARSE,
   output logic [FW-1:0] DCO_FINE,
   output logic          CAL_DONE,
   output logic          freq_lock
);

   localparam int AW = $clog2(SETTLE_CYC) + 2;
   localparam int WW = $clog2(SETTLE_CYC);
   localparam int BW = $clog2(CW);
   localparam logic [CW-1:0] MID_C    = CW'(mid_code(CW));
   localparam logic [FW-1:0] MID_F    = FW'(mid_code(FW));
   localparam logic [FW-1:0] FMAX     = {FW{1'b1}};
   localparam logic [WW-1:0] WIN_LAST = WW'(SETTLE_CYC - 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         sar_q, sar_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [WW-1:0]         win_q, win_d;
   logic signed [AW-1:0]  acc_q, acc_d, acc_step, acc_sum;
   logic [FW-1:0]         fine_q, fine_d, step;
   logic                  cal_q, cal_d, lock_q, lock_d;
   logic [2:0]            m_q;
   dir_t                  dir;
   logic                  clr, rail, rev_hit, lock_hit, loss_hit;

   assign dir  = pfd_dir(PFD_UP, PFD_DN);
   assign clr  = (state_q != ST_FINE);
   assign rail = (fine_q == '0) || (fine_q == FMAX);

   adpll_lock_detect #(
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CYC (LOSS_CYC)
   ) u_lock_detect (
      .clk        (REF_CLK),
      .rst        (RESET),
      .clr_i      (clr),
      .dir_i      (dir),
      .rail_i     (rail),
      .rev_hit_o  (rev_hit),
      .lock_hit_o (lock_hit),
      .loss_hit_o (loss_hit)
   );

`ifdef ADPLL_FAST_TRACK_EN
   logic fast_q;
   assign step = (fast_q && !rev_hit) ? FW'(4) : FW'(1);
   always_ff @(posedge REF_CLK or posedge RESET) begin
      if (RESET)                 fast_q <= 1'b0;
      else if (state_q != ST_FINE) fast_q <= 1'b1;
      else if (rev_hit)          fast_q <= 1'b0;
   end
`else
   assign step = FW'(1);
`endif

   always_comb begin
      case (dir)
         DIR_UP:  acc_step = AW'(1);
         DIR_DN:  acc_step = '1;
         default: acc_step = '0;
      endcase
      acc_sum = acc_q + acc_step;
   end

   always_comb begin
      state_d = state_q;
      sar_d   = sar_q;
      bit_d   = bit_q;
      win_d   = win_q;
      acc_d   = acc_q;
      fine_d  = fine_q;
      cal_d   = cal_q;
      lock_d  = lock_q;
      if (!START) begin
         state_d = ST_IDLE;
         sar_d   = MID_C;
         bit_d   = BW'(CW - 1);
         win_d   = '0;
         acc_d   = '0;
         fine_d  = MID_F;
         cal_d   = 1'b0;
         lock_d  = 1'b0;
      end else if (state_q == ST_IDLE || M != m_q || loss_hit) begin
         state_d = ST_COARSE;
         sar_d   = MID_C;
         bit_d   = BW'(CW - 1);
         win_d   = '0;
         acc_d   = '0;
         fine_d  = MID_F;
         cal_d   = 1'b0;
         lock_d  = 1'b0;
      end else begin
         case (state_q)
            ST_COARSE: begin
               if (win_q == WIN_LAST) begin
                  win_d = '0;
                  acc_d = '0;
                  // Trial bit survives only on a net-slow verdict over the window.
                  if (acc_sum[AW-1] || acc_sum == '0) sar_d[bit_q] = 1'b0;
                  if (bit_q == '0) begin
                     state_d = ST_FINE;
                     fine_d  = MID_F;
                     cal_d   = 1'b1;
                  end else begin
                     bit_d = bit_q - BW'(1);
                     sar_d[bit_q - BW'(1)] = 1'b1;
                  end
               end else begin
                  win_d = win_q + WW'(1);
                  acc_d = acc_sum;
               end
            end
            ST_FINE: begin
               lock_d = lock_q | lock_hit;
               if (dir == DIR_UP)
                  fine_d = (fine_q > FMAX - step) ? FMAX : fine_q + step;
               else if (dir == DIR_DN)
                  fine_d = (fine_q < step) ? '0 : fine_q - step;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge REF_CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         sar_q   <= MID_C;
         bit_q   <= BW'(CW - 1);
         win_q   <= '0;
         acc_q   <= '0;
         fine_q  <= MID_F;
         cal_q   <= 1'b0;
         lock_q  <= 1'b0;
         m_q     <= '0;
      end else begin
         state_q <= state_d;
         sar_q   <= sar_d;
         bit_q   <= bit_d;
         win_q   <= win_d;
         acc_q   <= acc_d;
         fine_q  <= fine_d;
         cal_q   <= cal_d;
         lock_q  <= lock_d;
         m_q     <= M;
      end
   end

   assign DCO_COARSE = sar_q;
   assign DCO_FINE   = fine_q;
   assign CAL_DONE   = cal_q;
   assign freq_lock  = lock_q;

endmodule
